// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared encodings and types for the UART receive channel
//  PAR_*       : runtime parity mode encodings (2'b11 behaves as none)
//  rx_state_t  : receiver FSM states
//  ENTRY_XTRA  : status bits stored with each data word ({ferr, perr, data})
//  par_enabled : true when a parity bit follows the data bits
package uart_pkg;

    localparam logic [1:0] PAR_NONE  = 2'b00;
    localparam logic [1:0] PAR_EVEN  = 2'b01;
    localparam logic [1:0] PAR_ODD   = 2'b10;
    localparam logic [1:0] PAR_NONE2 = 2'b11;

    localparam int ENTRY_XTRA = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    function automatic logic par_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_fifo.sv
// rtl/uart_rx_ctrl_fifo.sv - synchronous FIFO with registered read port
//  clk, rst          : clock, async active-low reset
//  wr_en, wr_data    : push (dropped when full)
//  rd_en, rd_data    : pop (ignored when empty); rd_data valid the cycle after rd_en
//  empty, full, count: occupancy status
module uart_rx_ctrl_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd_en,
    output logic [W-1:0]             rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_wr;
    logic          do_rd;

    assign empty = (cnt == '0);
    assign full  = (cnt == (AW+1)'(DEPTH));
    assign count = cnt;
    // Full is judged before any same-cycle pop, so a push into a full FIFO is always lost.
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            rd_data <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= mem[rd_ptr];
            end
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - oversampled UART receiver with error flags and RX FIFO
//  Optional feature macro: UART_RX_TIMEOUT_EN (idle timeout with data pending)
//  clk, rst            : clock, async active-low reset
//  baud_div            : clk cycles per oversample tick (0 behaves as 1)
//  par_mode            : 00 none, 01 even, 10 odd, 11 none
//  rx_data             : asynchronous serial line, idle high
//  rd_en               : pop head entry
//  rd_data/perr/ferr   : popped frame, valid the cycle after rd_en
//  empty, full, count  : FIFO status
//  overrun, clr_overrun: sticky frame-dropped flag and its clear
//  timeout             : idle timeout with unread data (0 when feature disabled)
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int D_W    = 8,
    parameter int B_TICK = 16,
    parameter int DEPTH  = 64,
    parameter int TO_CHR = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [15:0]            baud_div,
    input  logic [1:0]             par_mode,
    input  logic                   rx_data,
    input  logic                   rd_en,
    output logic [D_W-1:0]         rd_data,
    output logic                   rd_perr,
    output logic                   rd_ferr,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overrun,
    input  logic                   clr_overrun,
    output logic                   timeout
);

    localparam int EW = D_W + ENTRY_XTRA;
    localparam int SW = $clog2(B_TICK);
    localparam int BW = $clog2(D_W);
    localparam logic [SW-1:0] LIM_HALF = SW'(B_TICK/2 - 1);
    localparam logic [SW-1:0] LIM_FULL = SW'(B_TICK - 1);

    if (D_W < 5 || D_W > 9 || B_TICK < 8 || (B_TICK % 2) != 0 || TO_CHR < 1) begin : g_bad_param
        $error("uart_rx_ctrl: parameter out of range");
    end

    logic          rx_s1;
    logic          rx_s2;
    logic [15:0]   tick_cnt;
    logic [15:0]   tick_reload;
    logic          tick;
    rx_state_t     state;
    rx_state_t     nxt;
    logic [SW-1:0] s_cnt;
    logic [BW-1:0] bit_cnt;
    logic [D_W-1:0] shreg;
    logic [1:0]    par_lat;
    logic          perr_r;
    logic          samp;
    logic          push;
    logic [EW-1:0] push_entry;
    logic [EW-1:0] pop_entry;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= rx_data;
            rx_s2 <= rx_s1;
        end
    end

    // Free-running tick divider; a new baud_div only takes effect on the next reload.
    assign tick_reload = (baud_div == 16'd0) ? 16'd0 : baud_div - 16'd1;
    assign tick        = (tick_cnt == 16'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= tick_reload;
        end else begin
            tick_cnt <= tick_cnt - 16'd1;
        end
    end

    // Start bit is checked at its midpoint; every later bit is a full bit-time further on.
    assign samp = tick && (s_cnt == ((state == ST_START) ? LIM_HALF : LIM_FULL));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:   if (!rx_s2) nxt = ST_START;
            ST_START:  if (samp) nxt = rx_s2 ? ST_IDLE : ST_DATA;
            ST_DATA:   if (samp && bit_cnt == BW'(D_W - 1))
                           nxt = par_enabled(par_lat) ? ST_PARITY : ST_STOP;
            ST_PARITY: if (samp) nxt = ST_STOP;
            ST_STOP:   if (samp) nxt = rx_s2 ? ST_IDLE : ST_BREAK;
            // Wait out a held-low line so it is not mistaken for a new start bit.
            ST_BREAK:  if (rx_s2) nxt = ST_IDLE;
            default:   nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        push       = 1'b0;
        push_entry = {!rx_s2, perr_r, shreg};
        if (state == ST_STOP && samp) begin
            push = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_cnt   <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            par_lat <= PAR_NONE;
            perr_r  <= 1'b0;
        end else if (state == ST_IDLE) begin
            s_cnt   <= '0;
            bit_cnt <= '0;
            perr_r  <= 1'b0;
        end else begin
            if (tick) begin
                s_cnt <= samp ? '0 : s_cnt + 1'b1;
            end
            if (samp) begin
                case (state)
                    ST_START:  par_lat <= par_mode;
                    ST_DATA: begin
                        shreg   <= {rx_s2, shreg[D_W-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    ST_PARITY: perr_r <= ((^shreg) ^ rx_s2) != (par_lat == PAR_ODD);
                    default:   ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun <= 1'b0;
        end else if (push && full) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end
    end

    uart_rx_ctrl_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (push_entry),
        .rd_en   (rd_en),
        .rd_data (pop_entry),
        .empty   (empty),
        .full    (full),
        .count   (count)
    );

    assign {rd_ferr, rd_perr, rd_data} = pop_entry;

`ifdef UART_RX_TIMEOUT_EN
    localparam logic [31:0] TO_LAST = 32'(TO_CHR * (D_W + 3) * B_TICK - 1);

    logic [31:0] idle_cnt;
    logic        to_r;
    logic        to_clr;

    assign to_clr  = rd_en || empty || (state != ST_IDLE) || !rx_s2;
    assign timeout = to_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt <= '0;
            to_r     <= 1'b0;
        end else if (to_clr) begin
            idle_cnt <= '0;
            to_r     <= 1'b0;
        end else if (tick) begin
            if (idle_cnt == TO_LAST) begin
                to_r <= 1'b1;
            end else begin
                idle_cnt <= idle_cnt + 32'd1;
            end
        end
    end
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - scoreboard bench for uart_rx_ctrl
module tb_uart_rx_ctrl;

    localparam int BIT_CLK = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] baud_div = 16'd4;
    logic [1:0]  par_mode = 2'b00;
    logic        rx_data = 1'b1;
    logic        rd_en = 1'b0;
    logic        clr_overrun = 1'b0;
    logic [7:0]  rd_data;
    logic        rd_perr;
    logic        rd_ferr;
    logic        empty;
    logic        full;
    logic [6:0]  count;
    logic        overrun;
    logic        timeout;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [9:0]  exp_q[$];
    logic        pop_pend = 1'b0;
    int          lat;

    always #5 clk = ~clk;

    uart_rx_ctrl #(.D_W(8), .B_TICK(16), .DEPTH(64), .TO_CHR(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .baud_div    (baud_div),
        .par_mode    (par_mode),
        .rx_data     (rx_data),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_perr     (rd_perr),
        .rd_ferr     (rd_ferr),
        .empty       (empty),
        .full        (full),
        .count       (count),
        .overrun     (overrun),
        .clr_overrun (clr_overrun),
        .timeout     (timeout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a pop accepted on one edge presents its entry by the following negedge.
    always @(posedge clk) pop_pend <= rd_en && !empty && rst;

    always @(negedge clk) begin
        if (pop_pend) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pop: got entry 0x%0h, required none", {rd_ferr, rd_perr, rd_data});
            end else begin
                chk("rx_entry {ferr,perr,data}", {22'd0, rd_ferr, rd_perr, rd_data}, {22'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic bit_time(input logic v);
        rx_data = v;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic send_body(input logic [7:0] d, input bit use_par, input logic pb);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(d[i]);
        if (use_par) bit_time(pb);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit use_par, input logic pb);
        send_body(d, use_par, pb);
        bit_time(1'b1);
    endtask

    task automatic pop_n(input int n);
        repeat (n) begin
            rd_en = 1'b1;
            @(negedge clk);
        end
        rd_en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_timeout", timeout, 0);
        rst = 1'b1;
        repeat (10) @(negedge clk);

        // 8N1 0xA5 with push latency from the start of the stop bit
        send_body(8'hA5, 1'b0, 1'b0);
        exp_q.push_back({2'b00, 8'hA5});
        rx_data = 1'b1;
        chk("t1_empty_before_stop", empty, 1);
        lat = 0;
        while (empty && lat < BIT_CLK) begin
            @(negedge clk);
            lat++;
        end
        chk("t1_push_latency_in_window", (lat >= 30 && lat <= 38), 1);
        repeat (BIT_CLK - lat) @(negedge clk);
        chk("t1_count", count, 1);
        pop_n(1);
        chk("t1_empty_after_pop", empty, 1);

        // parity modes on 0x07 (three ones)
        par_mode = 2'b01;
        send_frame(8'h07, 1'b1, 1'b0); exp_q.push_back({2'b01, 8'h07});
        send_frame(8'h07, 1'b1, 1'b1); exp_q.push_back({2'b00, 8'h07});
        par_mode = 2'b10;
        send_frame(8'h07, 1'b1, 1'b0); exp_q.push_back({2'b00, 8'h07});
        send_frame(8'h07, 1'b1, 1'b1); exp_q.push_back({2'b01, 8'h07});
        par_mode = 2'b11;
        send_frame(8'h07, 1'b0, 1'b0); exp_q.push_back({2'b00, 8'h07});
        par_mode = 2'b00;
        chk("t2_count", count, 5);
        pop_n(5);

        // stop bit held low for three bit-times, then a clean frame
        send_body(8'h55, 1'b0, 1'b0);
        exp_q.push_back({2'b10, 8'h55});
        rx_data = 1'b0;
        repeat (3 * BIT_CLK) @(negedge clk);
        bit_time(1'b1);
        bit_time(1'b1);
        chk("t3_count_break", count, 1);
        send_frame(8'h3C, 1'b0, 1'b0);
        exp_q.push_back({2'b00, 8'h3C});
        chk("t3_count_after", count, 2);
        pop_n(2);

        // four-tick low glitch on an idle line
        rx_data = 1'b0;
        repeat (16) @(negedge clk);
        rx_data = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
        chk("t4_empty", empty, 1);
        chk("t4_count", count, 0);
        send_frame(8'h81, 1'b0, 1'b0);
        exp_q.push_back({2'b00, 8'h81});
        pop_n(1);

        // DEPTH+1 frames with no reads: last one is dropped
        for (int i = 0; i <= 64; i++) begin
            send_frame(8'(i), 1'b0, 1'b0);
            if (i < 64) exp_q.push_back({2'b00, 8'(i)});
        end
        chk("t5_full", full, 1);
        chk("t5_count", count, 64);
        chk("t5_overrun", overrun, 1);
        pop_n(64);
        chk("t5_count_drained", count, 0);
        chk("t5_overrun_sticky", overrun, 1);
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        @(negedge clk);
        chk("t5_overrun_cleared", overrun, 0);

        // reset in the middle of data bit 3
        send_frame(8'h11, 1'b0, 1'b0);
        chk("t6_count_pre", count, 1);
        bit_time(1'b0);
        for (int i = 0; i < 3; i++) bit_time(1'(8'h5A >> i));
        rx_data = 1'b1;
        repeat (32) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t6_rst_empty", empty, 1);
        chk("t6_rst_count", count, 0);
        chk("t6_rst_rd_data", rd_data, 0);
        chk("t6_rst_full", full, 0);
        exp_q.delete();
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (BIT_CLK) @(negedge clk);
        send_frame(8'h5A, 1'b0, 1'b0);
        exp_q.push_back({2'b00, 8'h5A});
        chk("t6_count_post", count, 1);

`ifdef UART_RX_TIMEOUT_EN
        repeat (2600) @(negedge clk);
        chk("t6_timeout_early", timeout, 0);
        lat = 0;
        while (!timeout && lat < 600) begin
            @(negedge clk);
            lat++;
        end
        chk("t6_timeout_set", timeout, 1);
        pop_n(1);
        chk("t6_timeout_cleared", timeout, 0);
`else
        repeat (3200) @(negedge clk);
        chk("t6_timeout_disabled", timeout, 0);
        pop_n(1);
`endif

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
